// File: rtl/vx_lru_tag_queue.sv
// Tag-addressed LRU queue: push appends as MRU, pop removes the LRU head,
// touch promotes a tag-matched entry to MRU, flush empties the queue.
module vx_lru_tag_queue #(
    parameter int DATAW     = 8,
    parameter int TAGW      = 16,
    parameter int DEPTH     = 4,
    parameter int ALM_FULL  = DEPTH - 1,
    parameter int ALM_EMPTY = 1,
    parameter int OUT_REG   = 0,
    parameter int SIZEW     = $clog2(DEPTH + 1),
    parameter int RANKW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [TAGW-1:0]  tag_in,
    input  logic [DATAW-1:0] data_in,
    input  logic             pop,
    input  logic             touch,
    input  logic [TAGW-1:0]  touch_tag,
    input  logic             flush,
    output logic [DATAW-1:0] data_out,
    output logic [TAGW-1:0]  tag_out,
    output logic             touch_hit,
    output logic [RANKW-1:0] touch_rank,
    output logic             empty,
    output logic             alm_empty,
    output logic             full,
    output logic             alm_full,
    output logic [SIZEW-1:0] size
);

    logic [TAGW-1:0]  r_tag   [DEPTH];
    logic [DATAW-1:0] r_data  [DEPTH];
    logic [RANKW-1:0] r_order [DEPTH];
    logic [DEPTH-1:0] r_free;
    logic [SIZEW-1:0] r_size;
    logic             r_empty, r_alm_empty, r_full, r_alm_full;

    logic             w_pop_eff, w_push_eff, w_hit, w_mv, w_found;
    logic [RANKW-1:0] w_rank, w_trank, w_slot;
    logic [SIZEW-1:0] w_size1, w_size_n, w_size_f;
    logic [DEPTH-1:0] w_free1, w_free_n;
    logic [RANKW-1:0] w_ord1  [DEPTH];
    logic [RANKW-1:0] w_ord2  [DEPTH];
    logic [RANKW-1:0] w_ord_n [DEPTH];

    assign w_pop_eff  = pop && (r_size != '0);
    assign w_push_eff = push && ((r_size != SIZEW'(DEPTH)) || w_pop_eff);
    assign w_size1    = w_pop_eff ? (r_size - SIZEW'(1)) : r_size;
    assign w_size_n   = w_size1 + SIZEW'(w_push_eff);
    assign w_size_f   = flush ? '0 : w_size_n;

    // Lowest-rank valid match wins, so a duplicated tag resolves to the older copy.
    always_comb begin
        w_hit  = 1'b0;
        w_rank = '0;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            if (!w_hit && (SIZEW'(r) < r_size) && (r_tag[r_order[r]] == touch_tag)) begin
                w_hit  = 1'b1;
                w_rank = RANKW'(r);
            end
        end
    end

    assign w_mv    = touch && w_hit && !(w_pop_eff && (w_rank == '0));
    assign w_trank = w_rank - RANKW'(w_pop_eff);

    always_comb begin
        w_free1 = r_free;
        if (w_pop_eff) w_free1[r_order[0]] = 1'b1;
        w_found = 1'b0;
        w_slot  = '0;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            if (!w_found && w_free1[r]) begin
                w_found = 1'b1;
                w_slot  = RANKW'(r);
            end
        end
        w_free_n = w_free1;
        if (w_push_eff) w_free_n[w_slot] = 1'b0;
    end

    // Order update in three stages: pop shifts down, touch rotates the tail, push appends.
    always_comb begin
        for (int unsigned r = 0; r < DEPTH - 1; r++)
            w_ord1[r] = w_pop_eff ? r_order[r+1] : r_order[r];
        w_ord1[DEPTH-1] = w_pop_eff ? '0 : r_order[DEPTH-1];

        for (int unsigned r = 0; r < DEPTH - 1; r++) begin
            if (w_mv && (RANKW'(r) >= w_trank) && ((SIZEW'(r) + SIZEW'(1)) < w_size1))
                w_ord2[r] = w_ord1[r+1];
            else if (w_mv && ((SIZEW'(r) + SIZEW'(1)) == w_size1))
                w_ord2[r] = w_ord1[w_trank];
            else
                w_ord2[r] = w_ord1[r];
        end
        w_ord2[DEPTH-1] = (w_mv && (w_size1 == SIZEW'(DEPTH))) ? w_ord1[w_trank] : w_ord1[DEPTH-1];

        for (int unsigned r = 0; r < DEPTH; r++)
            w_ord_n[r] = (w_push_eff && (SIZEW'(r) == w_size1)) ? w_slot : w_ord2[r];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_size <= '0;
            r_free <= '1;
            for (int unsigned r = 0; r < DEPTH; r++) begin
                r_order[r] <= '0;
                r_tag[r]   <= '0;
                r_data[r]  <= '0;
            end
        end else if (flush) begin
            r_size <= '0;
            r_free <= '1;
            for (int unsigned r = 0; r < DEPTH; r++) r_order[r] <= '0;
        end else begin
            r_size  <= w_size_n;
            r_free  <= w_free_n;
            r_order <= w_ord_n;
            if (w_push_eff) begin
                r_tag[w_slot]  <= tag_in;
                r_data[w_slot] <= data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_empty     <= 1'b1;
            r_alm_empty <= 1'b1;
            r_full      <= 1'b0;
            r_alm_full  <= 1'b0;
        end else begin
            r_empty     <= (w_size_f == '0);
            r_alm_empty <= (w_size_f <= SIZEW'(ALM_EMPTY));
            r_full      <= (w_size_f == SIZEW'(DEPTH));
            r_alm_full  <= (w_size_f >= SIZEW'(ALM_FULL));
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [TAGW-1:0]  r_tag_o, w_tag_nh;
            logic [DATAW-1:0] r_data_o, w_data_nh;

            // Next head is the pushed entry only when nothing else survives this cycle.
            always_comb begin
                w_tag_nh  = r_tag[w_ord_n[0]];
                w_data_nh = r_data[w_ord_n[0]];
                if (w_push_eff && (w_size1 == '0)) begin
                    w_tag_nh  = tag_in;
                    w_data_nh = data_in;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_tag_o  <= '0;
                    r_data_o <= '0;
                end else if (w_size_f != '0) begin
                    r_tag_o  <= w_tag_nh;
                    r_data_o <= w_data_nh;
                end
            end

            assign tag_out  = r_tag_o;
            assign data_out = r_data_o;
        end else begin : g_ocomb
            assign tag_out  = r_empty ? r_tag[0]  : r_tag[r_order[0]];
            assign data_out = r_empty ? r_data[0] : r_data[r_order[0]];
        end
    endgenerate

    assign touch_hit  = w_hit;
    assign touch_rank = w_rank;
    assign empty      = r_empty;
    assign alm_empty  = r_alm_empty;
    assign full       = r_full;
    assign alm_full   = r_alm_full;
    assign size       = r_size;

    a_push_full: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && !flush && (r_size == SIZEW'(DEPTH))));
    a_pop_empty: assert property (@(posedge clk) disable iff (reset)
        !(pop && !flush && (r_size == '0)));

endmodule

// File: tb/tb_vx_lru_tag_queue.sv
// Scoreboard bench for vx_lru_tag_queue: DEPTH=4 combinational-output and
// DEPTH=3 registered-output instances, exercised one at a time by sel.
module tb_vx_lru_tag_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, push, pop, touch, flush, sel;
    logic [15:0] tag_in, touch_tag;
    logic [7:0]  data_in;

    logic [7:0]  d0_data, d1_data;
    logic [15:0] d0_tag, d1_tag;
    logic        d0_hit, d1_hit, d0_em, d1_em, d0_ae, d1_ae, d0_fu, d1_fu, d0_af, d1_af;
    logic [1:0]  d0_rank, d1_rank, d1_size;
    logic [2:0]  d0_size;

    vx_lru_tag_queue #(.DEPTH(4), .OUT_REG(0)) u_d4 (
        .clk(clk), .reset(rst),
        .push(push & ~sel), .tag_in(tag_in), .data_in(data_in),
        .pop(pop & ~sel), .touch(touch & ~sel), .touch_tag(touch_tag), .flush(flush & ~sel),
        .data_out(d0_data), .tag_out(d0_tag), .touch_hit(d0_hit), .touch_rank(d0_rank),
        .empty(d0_em), .alm_empty(d0_ae), .full(d0_fu), .alm_full(d0_af), .size(d0_size));

    vx_lru_tag_queue #(.DEPTH(3), .OUT_REG(1)) u_d3 (
        .clk(clk), .reset(rst),
        .push(push & sel), .tag_in(tag_in), .data_in(data_in),
        .pop(pop & sel), .touch(touch & sel), .touch_tag(touch_tag), .flush(flush & sel),
        .data_out(d1_data), .tag_out(d1_tag), .touch_hit(d1_hit), .touch_rank(d1_rank),
        .empty(d1_em), .alm_empty(d1_ae), .full(d1_fu), .alm_full(d1_af), .size(d1_size));

    logic [7:0]  m_data;
    logic [15:0] m_tag;
    logic        m_hit, m_em, m_ae, m_fu, m_af;
    logic [1:0]  m_rank;
    logic [2:0]  m_size;

    always_comb begin
        m_data = sel ? d1_data : d0_data;
        m_tag  = sel ? d1_tag  : d0_tag;
        m_hit  = sel ? d1_hit  : d0_hit;
        m_rank = sel ? d1_rank : d0_rank;
        m_em   = sel ? d1_em   : d0_em;
        m_ae   = sel ? d1_ae   : d0_ae;
        m_fu   = sel ? d1_fu   : d0_fu;
        m_af   = sel ? d1_af   : d0_af;
        m_size = sel ? {1'b0, d1_size} : d0_size;
    end

    localparam logic [15:0] TA = 16'h000A, TB = 16'h000B, TC = 16'h000C,
                            TD = 16'h000D, TE = 16'h000E, TF = 16'h000F, TZ = 16'h00FF;

    typedef struct { logic hit; logic [1:0] rank; } tch_t;
    logic [15:0] q_pop[$];
    tch_t        q_tch[$];
    int checks = 0, failures = 0;
    int dep;

    function automatic logic [7:0] dat(input logic [15:0] t);
        return t[7:0] ^ 8'hA5;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut=%0d sel=%0d actual=%0d expected=%0d", name, sel, sel, act, exp);
        end
    endtask

    // Monitor: whenever a pop or touch is presented, compare against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (pop) begin
                if (q_pop.size() == 0) chk("pop_unexpected", 1, 0);
                else begin
                    automatic logic [15:0] t = q_pop.pop_front();
                    chk("pop_tag", int'(m_tag), int'(t));
                    chk("pop_data", int'(m_data), int'(dat(t)));
                end
            end
            if (touch) begin
                if (q_tch.size() == 0) chk("touch_unexpected", 1, 0);
                else begin
                    automatic tch_t e = q_tch.pop_front();
                    chk("touch_hit", int'(m_hit), int'(e.hit));
                    chk("touch_rank", int'(m_rank), int'(e.rank));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; touch = 1'b0; flush = 1'b0; rst = 1'b0;
    endtask

    task automatic do_push(input logic [15:0] t);
        push = 1'b1; tag_in = t; data_in = dat(t);
    endtask

    task automatic exp_pop(input logic [15:0] t);
        pop = 1'b1; q_pop.push_back(t);
    endtask

    task automatic exp_touch(input logic [15:0] t, input logic h, input logic [1:0] r);
        tch_t e;
        e.hit = h; e.rank = r;
        touch = 1'b1; touch_tag = t; q_tch.push_back(e);
    endtask

    task automatic status(input string name, input int sz);
        chk({name, "_size"}, int'(m_size), sz);
        chk({name, "_empty"}, int'(m_em), int'(sz == 0));
        chk({name, "_full"}, int'(m_fu), int'(sz == dep));
        chk({name, "_alm_full"}, int'(m_af), int'(sz >= dep - 1));
        chk({name, "_alm_empty"}, int'(m_ae), int'(sz <= 1));
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) begin
            do_push(TA + 16'(i));
            cyc();
        end
    endtask

    task automatic run_scenarios();
        logic [15:0] order[$];
        dep = sel ? 3 : 4;

        // Fill to full, then drain in FIFO order.
        for (int i = 0; i < dep; i++) begin
            do_push(TA + 16'(i));
            cyc();
            status("fill", i + 1);
            chk("fill_head", int'(m_tag), int'(TA));
        end
        for (int i = 0; i < dep; i++) begin
            exp_pop(TA + 16'(i));
            cyc();
            status("drain", dep - 1 - i);
        end

        // Touch the LRU entry, it becomes MRU.
        push_n(3);
        exp_touch(TA, 1'b1, 2'd0);
        cyc();
        chk("touch_head", int'(m_tag), int'(TB));
        exp_pop(TB); cyc();
        exp_pop(TC); cyc();
        exp_pop(TA); cyc();
        status("touch_drain", 0);

        // Full queue: pop + push E + touch C in one cycle.
        push_n(dep);
        exp_pop(TA);
        exp_touch(TC, 1'b1, 2'd2);
        do_push(TE);
        cyc();
        status("combo", dep);
        order = {};
        for (int i = 1; i < dep; i++) if ((TA + 16'(i)) != TC) order.push_back(TA + 16'(i));
        order.push_back(TC);
        order.push_back(TE);
        foreach (order[i]) begin
            exp_pop(order[i]);
            cyc();
        end
        status("combo_drain", 0);

        // Touch the head being popped, then touch an absent tag.
        push_n(2);
        exp_pop(TA);
        exp_touch(TA, 1'b1, 2'd0);
        cyc();
        status("headtouch", 1);
        exp_touch(TZ, 1'b0, 2'd0);
        cyc();
        chk("miss_head", int'(m_tag), int'(TB));
        exp_pop(TB); cyc();
        status("miss_drain", 0);

        // Flush beats a concurrent push; touch still reports.
        push_n(3);
        flush = 1'b1;
        do_push(TD);
        exp_touch(TB, 1'b1, 2'd1);
        cyc();
        status("flush", 0);
        do_push(TF); cyc();
        chk("post_flush_head", int'(m_tag), int'(TF));
        status("post_flush", 1);
        exp_pop(TF); cyc();

        // Reset mid-operation discards everything.
        push_n(3);
        status("prereset", 3);
        rst = 1'b1;
        do_push(TD);
        cyc();
        status("reset", 0);
        chk("reset_tag", int'(m_tag), 0);
        chk("reset_data", int'(m_data), 0);
        chk("reset_hit", int'(m_hit), 0);
        chk("reset_rank", int'(m_rank), 0);
        do_push(TF); cyc();
        chk("after_reset_head", int'(m_tag), int'(TF));
        exp_pop(TF); cyc();
        status("final", 0);
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; touch = 1'b0; flush = 1'b0; sel = 1'b0;
        tag_in = '0; data_in = '0; touch_tag = 16'h1234;
        cyc(); rst = 1'b1; cyc();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            dep = sel ? 3 : 4;
            #1;
            status("init", 0);
            chk("init_tag", int'(m_tag), 0);
            chk("init_data", int'(m_data), 0);
            chk("init_hit", int'(m_hit), 0);
            chk("init_rank", int'(m_rank), 0);
            run_scenarios();
        end
        @(negedge clk);
        chk("scoreboard_drained", q_pop.size() + q_tch.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
